// File: rtl/hmmm_memory.sv
// Unified 256 x 15-bit instruction/data memory for the HMMM core, with a byte-stream
// program loader that holds the core in reset and a memory-mapped output register.
module hmmm_memory #(
    parameter int              AW       = 8,
    parameter int              IW       = 15,
    parameter int              DW       = 8,
    parameter logic [AW-1:0]   OUT_ADDR = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] WriteData,
    output logic [IW-1:0] ReadData,
    output logic          cpu_reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_HDR,
        ST_LO,
        ST_HI,
        ST_RUN
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(1 << AW);
    localparam logic [AW:0] LAST_WORD  = (AW+1)'(1);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_remaining;
    logic [7:0]    r_lo;
    logic [IW-1:0] r_mem [0:(1<<AW)-1];

    logic          w_accept;
    logic          w_load_we;
    logic          w_core_we;
    logic          w_out_we;
    logic [IW-1:0] w_load_word;

    assign load_ready  = (r_state != ST_RUN);
    assign w_accept    = load_valid && load_ready;
    assign w_load_we   = (r_state == ST_HI) && w_accept;
    // The high byte's top bit is dropped; the word is {hi[6:0], lo}.
    assign w_load_word = {load_data[IW-9:0], r_lo};
    assign w_core_we   = !cpu_reset && MemWrite && (adr != OUT_ADDR);
    assign w_out_we    = !cpu_reset && MemWrite && (adr == OUT_ADDR);
    assign ReadData    = r_mem[adr];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HDR:  if (w_accept) w_next_state = ST_LO;
            ST_LO:   if (w_accept) w_next_state = ST_HI;
            ST_HI:   if (w_accept) w_next_state = (r_remaining == LAST_WORD) ? ST_RUN : ST_LO;
            ST_RUN:  if (load_start) w_next_state = ST_HDR;
            default: w_next_state = ST_HDR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_HDR;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_lo        <= '0;
            cpu_reset   <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            r_state   <= w_next_state;
            cpu_reset <= (w_next_state != ST_RUN);
            out_valid <= w_out_we;
            if (w_out_we) out_data <= WriteData;

            if (w_accept) begin
                case (r_state)
                    ST_HDR: begin
                        r_remaining <= (load_data == 8'd0) ? FULL_COUNT : (AW+1)'(load_data);
                        r_ptr       <= '0;
                    end
                    ST_LO: r_lo <= load_data;
                    ST_HI: begin
                        r_ptr <= r_ptr + 1'b1;
                        if (r_remaining > LAST_WORD) r_remaining <= r_remaining - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the array has no reset so it maps onto RAM and keeps its contents across
    // a reset; only the loader and the core ever change it.
    always_ff @(posedge clk) begin
        if (w_load_we)      r_mem[r_ptr] <= w_load_word;
        else if (w_core_we) r_mem[adr]   <= IW'(WriteData);
    end

endmodule

// File: tb/tb_hmmm_memory.sv
// Self-checking bench for hmmm_memory: random load streams and core stores checked
// against a word-level model of memory contents.
module tb_hmmm_memory;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [7:0]  adr;
    logic [7:0]  WriteData;
    logic [14:0] ReadData;
    logic        cpu_reset;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        out_valid;
    logic [7:0]  out_data;

    logic [14:0] model_mem   [256];
    bit          model_known [256];
    int          tests_run    = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    hmmm_memory dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .adr       (adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .cpu_reset (cpu_reset),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = b;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = 8'($urandom);
    endtask

    task automatic send_bytes(input byte_q_t q, input int max_gap);
        foreach (q[i]) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            send_byte(q[i]);
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    // Loads n words (random, or word i = i when counting) and checks cpu_reset
    // drops exactly on the edge that takes the final byte.
    task automatic make_load(input int n, input int max_gap, input bit counting, input string name);
        byte_q_t     q;
        logic [7:0]  last;
        logic [7:0]  lo;
        logic [7:0]  hi;
        q.push_back(8'(n == 256 ? 0 : n));
        for (int i = 0; i < n; i++) begin
            lo = counting ? 8'(i) : 8'($urandom);
            hi = counting ? {1'($urandom), 7'b0} : 8'($urandom);
            q.push_back(lo);
            q.push_back(hi);
            model_mem[i]   = 15'((int'(hi) % 128) * 256 + int'(lo));
            model_known[i] = 1'b1;
        end
        last = q.pop_back();
        send_bytes(q, max_gap);
        tests_run++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_before_last: cpu_reset=%b load_ready=%b required 1/1", name, cpu_reset, load_ready);
        end
        send_byte(last);
        tests_run++;
        if (cpu_reset !== 1'b0 || load_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_after_last: cpu_reset=%b load_ready=%b required 0/0", name, cpu_reset, load_ready);
        end
    endtask

    task automatic verify_memory(input string name);
        for (int a = 0; a < 256; a++) begin
            if (model_known[a]) begin
                adr = 8'(a);
                #1;
                tests_run++;
                if (ReadData !== model_mem[a]) begin
                    tests_failed++;
                    $display("FAIL %s_mem[%02h]: got %04h required %04h", name, a, ReadData, model_mem[a]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MemWrite = 1'b0; adr = '0; WriteData = '0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: cpu_reset=%b load_ready=%b out_valid=%b out_data=%02h required 1/1/0/00",
                     cpu_reset, load_ready, out_valid, out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: cpu_reset=%b load_ready=%b required 1/1", cpu_reset, load_ready);
        end
    endtask

    task automatic test_basic_load();
        byte_q_t q = '{8'h02, 8'h34, 8'h12, 8'hFF};
        send_bytes(q, 0);
        tests_run++;
        if (cpu_reset !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_before_5th: cpu_reset=%b required 1", cpu_reset);
        end
        send_byte(8'h7F);
        tests_run++;
        if (cpu_reset !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_after_5th: cpu_reset=%b required 0", cpu_reset);
        end
        model_mem[0] = 15'h1234; model_known[0] = 1'b1;
        model_mem[1] = 15'h7FFF; model_known[1] = 1'b1;
        verify_memory("basic");
    endtask

    task automatic test_gapped_load();
        byte_q_t q = '{8'h02, 8'h34, 8'h12, 8'hFF, 8'h7F};
        start_load();
        tests_run++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_start: cpu_reset=%b load_ready=%b required 1/1", cpu_reset, load_ready);
        end
        send_bytes(q, 3);
        tests_run++;
        if (cpu_reset !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_run: cpu_reset=%b required 0", cpu_reset);
        end
        verify_memory("gap_fixed");
        start_load();
        make_load($urandom_range(12, 3), 3, 1'b0, "gap_random");
        verify_memory("gap_random");
    endtask

    task automatic test_full_load();
        start_load();
        make_load(256, 0, 1'b1, "full");
        verify_memory("full");
        start_load();
        make_load(2, 1, 1'b0, "short_after_full");
        verify_memory("beyond_n");
    endtask

    task automatic test_core_write();
        logic [7:0] a;
        logic [7:0] d;
        @(negedge clk);
        adr = 8'h10; WriteData = 8'hAB; MemWrite = 1'b1;
        #1;
        tests_run++;
        if (ReadData !== model_mem[8'h10]) begin
            tests_failed++;
            $display("FAIL core_no_bypass: got %04h required %04h", ReadData, model_mem[8'h10]);
        end
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        model_mem[8'h10] = 15'h00AB;
        tests_run++;
        if (ReadData !== 15'h00AB) begin
            tests_failed++;
            $display("FAIL core_write_10: got %04h required 00ab", ReadData);
        end
        for (int k = 0; k < 6; k++) begin
            a = 8'($urandom_range(254, 0));
            d = 8'($urandom);
            @(negedge clk);
            adr = a; WriteData = d; MemWrite = 1'b1;
            @(posedge clk);
            #1;
            MemWrite = 1'b0;
            model_mem[a] = 15'(d);
        end
        verify_memory("core_random");
        start_load();
        @(negedge clk);
        adr = 8'h10; WriteData = 8'hCD; MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        tests_run++;
        if (ReadData !== model_mem[8'h10]) begin
            tests_failed++;
            $display("FAIL core_write_in_reset: got %04h required %04h", ReadData, model_mem[8'h10]);
        end
        make_load(1, 0, 1'b0, "reload_one");
        verify_memory("after_reload");
    endtask

    task automatic test_out_register();
        @(negedge clk);
        adr = 8'hFF; WriteData = 8'h5A; MemWrite = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL out_pre: out_valid=%b required 0", out_valid);
        end
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL out_pulse: out_valid=%b out_data=%02h required 1/5a", out_valid, out_data);
        end
        tests_run++;
        if (ReadData !== model_mem[8'hFF]) begin
            tests_failed++;
            $display("FAIL out_mem_ff: got %04h required %04h", ReadData, model_mem[8'hFF]);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL out_hold: out_valid=%b out_data=%02h required 0/5a", out_valid, out_data);
        end
    endtask

    task automatic test_start_with_write();
        @(negedge clk);
        load_start = 1'b1; MemWrite = 1'b1; adr = 8'h20; WriteData = 8'h77;
        @(posedge clk);
        #1;
        load_start = 1'b0; MemWrite = 1'b0;
        model_mem[8'h20] = 15'h0077;
        tests_run++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_write_state: cpu_reset=%b load_ready=%b required 1/1", cpu_reset, load_ready);
        end
        tests_run++;
        if (ReadData !== 15'h0077) begin
            tests_failed++;
            $display("FAIL start_write_mem20: got %04h required 0077", ReadData);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] lo0;
        logic [7:0] hi0;
        byte_q_t    q;
        lo0 = 8'($urandom);
        hi0 = 8'($urandom);
        q = '{8'h03, lo0, hi0, 8'($urandom)};
        send_bytes(q, 1);
        model_mem[0] = 15'((int'(hi0) % 128) * 256 + int'(lo0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_state: cpu_reset=%b load_ready=%b required 1/1", cpu_reset, load_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        verify_memory("mid_reset");
        make_load(2, 2, 1'b0, "after_mid_reset");
        verify_memory("after_mid_reset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_known[i] = 1'b0;
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_full_load();
        test_core_write();
        test_out_register();
        test_start_with_write();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
